// File: rtl/tx_sequence_recorder_if.sv
// tx_sequence_recorder_if: write/read bus between the Tx arbiter (master) and the sequence recorder (slave).
// Status signals exist only when TX_SEQ_REC_STATUS_EN is defined.
interface tx_sequence_recorder_if #(
  parameter int DATA_WIDTH = 3,
  parameter int FIFO_DEPTH = 10,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
);
  logic                  wr_en;
  logic [2:0]            wr_mode;
  logic [DATA_WIDTH-1:0] wr_data_1;
  logic [DATA_WIDTH-1:0] wr_data_2;
  logic [DATA_WIDTH-1:0] wr_data_3;
  logic [DATA_WIDTH-1:0] wr_data_4;
  logic                  rd_en;
  logic [1:0]            rd_mode;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   available;
`ifdef TX_SEQ_REC_STATUS_EN
  logic                  err_clr;
  logic                  overflow_err;
  logic                  underflow_err;
  modport master(
    output wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode, err_clr,
    input  rd_data_1, rd_data_2, empty, full, available, overflow_err, underflow_err
  );
  modport slave(
    input  wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode, err_clr,
    output rd_data_1, rd_data_2, empty, full, available, overflow_err, underflow_err
  );
`else
  modport master(
    output wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode,
    input  rd_data_1, rd_data_2, empty, full, available
  );
  modport slave(
    input  wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode,
    output rd_data_1, rd_data_2, empty, full, available
  );
`endif
endinterface

// File: rtl/tx_sequence_recorder.sv
// tx_sequence_recorder: source-ID FIFO accepting 0-4 IDs per cycle and exposing/popping the two oldest.
// Optional sticky overflow/underflow status is enabled by defining TX_SEQ_REC_STATUS_EN.
module tx_sequence_recorder #(
  parameter int DATA_WIDTH = 3,
  parameter int FIFO_DEPTH = 10,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input logic                   clk,
  input logic                   arst,
  tx_sequence_recorder_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wr_data [4];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         available;
  logic [CW-1:0]         n_wr;
  logic [CW-1:0]         n_rd;
  logic [CW-1:0]         rd_req;
  logic                  wr_ok;
  function automatic logic [ADDR_WIDTH-1:0] wrap(input logic [31:0] v);
    return ADDR_WIDTH'(v % 32'(FIFO_DEPTH));
  endfunction
  // Acceptance uses pre-edge space only, so there is no read-to-write combinational path
  always_comb begin
    wr_data   = '{bus.wr_data_1, bus.wr_data_2, bus.wr_data_3, bus.wr_data_4};
    available = CW'(FIFO_DEPTH) - count;
    wr_ok     = bus.wr_en && bus.wr_mode != 3'd0 && bus.wr_mode <= 3'd4 && 32'(bus.wr_mode) <= 32'(available);
    n_wr      = wr_ok ? CW'(bus.wr_mode) : '0;
    rd_req    = bus.rd_mode == 2'd3 ? CW'(2) : CW'(bus.rd_mode);
    n_rd      = !bus.rd_en ? '0 : rd_req < count ? rd_req : count;
  end
  assign bus.available = available;
  assign bus.empty     = count == '0;
  assign bus.full      = count == CW'(FIFO_DEPTH);
  assign bus.rd_data_1 = count == '0 ? '0 : mem[rd_ptr];
  assign bus.rd_data_2 = count < CW'(2) ? '0 : mem[wrap(32'(rd_ptr) + 32'd1)];
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (wr_ok && 32'(k) < 32'(bus.wr_mode)) mem[wrap(32'(wr_ptr) + 32'(k))] <= wr_data[k];
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wrap(32'(wr_ptr) + 32'(n_wr));
      rd_ptr <= wrap(32'(rd_ptr) + 32'(n_rd));
      count  <= count + n_wr - n_rd;
    end
`ifdef TX_SEQ_REC_STATUS_EN
  logic ovf_q, udf_q, ovf_set, udf_set;
  assign ovf_set = bus.wr_en && bus.wr_mode != 3'd0 && !wr_ok;
  assign udf_set = bus.rd_en && CW'(bus.rd_mode) > count;
  // A same-cycle set beats err_clr
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
      udf_q <= udf_set | (udf_q & ~bus.err_clr);
    end
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;
`endif
endmodule

// File: tb/tb_tx_sequence_recorder.sv
// tb_tx_sequence_recorder: directed self-checking bench for tx_sequence_recorder (depth 10, 3-bit IDs).
module tb_tx_sequence_recorder;
  logic clk = 1'b0;
  logic arst;
  int checks = 0;
  int errors = 0;
  tx_sequence_recorder_if bus();
  tx_sequence_recorder dut (.clk(clk), .arst(arst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc(input logic we, input logic [2:0] wm, input logic [2:0] d1, input logic [2:0] d2,
                     input logic [2:0] d3, input logic [2:0] d4, input logic re, input logic [1:0] rm);
    bus.wr_en = we; bus.wr_mode = wm;
    bus.wr_data_1 = d1; bus.wr_data_2 = d2; bus.wr_data_3 = d3; bus.wr_data_4 = d4;
    bus.rd_en = re; bus.rd_mode = rm;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask
  task automatic wr(input logic [2:0] wm, input logic [2:0] d1, input logic [2:0] d2, input logic [2:0] d3, input logic [2:0] d4);
    cyc(1'b1, wm, d1, d2, d3, d4, 1'b0, 2'd0);
  endtask
  task automatic pop(input logic [1:0] rm);
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, rm);
  endtask
  task automatic test_reset;
    #12;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0d exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", bus.full); end
    checks++; if (bus.available !== 5'd10) begin errors++; $display("FAIL reset_available got %0d exp 10", bus.available); end
    checks++; if (bus.rd_data_1 !== 3'd0 || bus.rd_data_2 !== 3'd0) begin errors++; $display("FAIL reset_rd_data got %0d,%0d exp 0,0", bus.rd_data_1, bus.rd_data_2); end
`ifdef TX_SEQ_REC_STATUS_EN
    checks++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0d,%0d exp 0,0", bus.overflow_err, bus.underflow_err); end
`endif
    @(negedge clk); arst = 1'b1;
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    checks++; if (bus.empty !== 1'b1 || bus.available !== 5'd10) begin errors++; $display("FAIL idle_state got empty=%0d avail=%0d exp 1,10", bus.empty, bus.available); end
  endtask
  task automatic test_order;
    wr(3'd4, 3'd1, 3'd2, 3'd3, 3'd5);
    wr(3'd3, 3'd2, 3'd3, 3'd4, 3'd0);
    checks++; if (bus.available !== 5'd3) begin errors++; $display("FAIL order_available got %0d exp 3", bus.available); end
    checks++; if (bus.rd_data_1 !== 3'd1 || bus.rd_data_2 !== 3'd2) begin errors++; $display("FAIL order_pair1 got %0d,%0d exp 1,2", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd3 || bus.rd_data_2 !== 3'd5) begin errors++; $display("FAIL order_pair2 got %0d,%0d exp 3,5", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd2 || bus.rd_data_2 !== 3'd3) begin errors++; $display("FAIL order_pair3 got %0d,%0d exp 2,3", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd4 || bus.rd_data_2 !== 3'd0) begin errors++; $display("FAIL order_pair4 got %0d,%0d exp 4,0", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd1);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL order_empty got %0d exp 1", bus.empty); end
  endtask
  task automatic test_overflow;
    wr(3'd4, 3'd1, 3'd2, 3'd3, 3'd4);
    wr(3'd4, 3'd5, 3'd1, 3'd2, 3'd3);
    wr(3'd1, 3'd4, 3'd0, 3'd0, 3'd0);
    checks++; if (bus.available !== 5'd1) begin errors++; $display("FAIL fill9_available got %0d exp 1", bus.available); end
    wr(3'd2, 3'd5, 3'd5, 3'd0, 3'd0);
    checks++; if (bus.available !== 5'd1 || bus.full !== 1'b0) begin errors++; $display("FAIL drop_state got avail=%0d full=%0d exp 1,0", bus.available, bus.full); end
`ifdef TX_SEQ_REC_STATUS_EN
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_err got %0d exp 1", bus.overflow_err); end
    bus.err_clr = 1'b1; cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0); bus.err_clr = 1'b0;
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL overflow_clr got %0d exp 0", bus.overflow_err); end
`endif
    wr(3'd1, 3'd1, 3'd0, 3'd0, 3'd0);
    checks++; if (bus.full !== 1'b1 || bus.available !== 5'd0) begin errors++; $display("FAIL full_state got full=%0d avail=%0d exp 1,0", bus.full, bus.available); end
    wr(3'd1, 3'd7, 3'd0, 3'd0, 3'd0);
    checks++; if (bus.full !== 1'b1 || bus.rd_data_1 !== 3'd1 || bus.rd_data_2 !== 3'd2) begin errors++; $display("FAIL full_head got full=%0d %0d,%0d exp 1,1,2", bus.full, bus.rd_data_1, bus.rd_data_2); end
    for (int i = 0; i < 4; i++) pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd4 || bus.rd_data_2 !== 3'd1) begin errors++; $display("FAIL drop_no_partial got %0d,%0d exp 4,1", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0d exp 1", bus.empty); end
  endtask
  task automatic test_wrap;
    wr(3'd1, 3'd6, 3'd0, 3'd0, 3'd0);
    pop(2'd1);
    wr(3'd4, 3'd1, 3'd2, 3'd3, 3'd4);
    checks++; if (bus.rd_data_1 !== 3'd1 || bus.rd_data_2 !== 3'd2) begin errors++; $display("FAIL wrap_pair1 got %0d,%0d exp 1,2", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd3 || bus.rd_data_2 !== 3'd4) begin errors++; $display("FAIL wrap_pair2 got %0d,%0d exp 3,4", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    wr(3'd2, 3'd5, 3'd6, 3'd0, 3'd0);
    checks++; if (bus.rd_data_1 !== 3'd5 || bus.rd_data_2 !== 3'd6) begin errors++; $display("FAIL wrap_wrptr got %0d,%0d exp 5,6", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd3);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_mode3_pop got empty=%0d exp 1", bus.empty); end
  endtask
  task automatic test_simultaneous;
    wr(3'd4, 3'd1, 3'd2, 3'd3, 3'd4);
    wr(3'd4, 3'd5, 3'd1, 3'd2, 3'd3);
    wr(3'd1, 3'd4, 3'd0, 3'd0, 3'd0);
    cyc(1'b1, 3'd2, 3'd5, 3'd5, 3'd0, 3'd0, 1'b1, 2'd2);
    checks++; if (bus.available !== 5'd3) begin errors++; $display("FAIL simul_drop_avail got %0d exp 3", bus.available); end
    checks++; if (bus.rd_data_1 !== 3'd3 || bus.rd_data_2 !== 3'd4) begin errors++; $display("FAIL simul_drop_head got %0d,%0d exp 3,4", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    cyc(1'b1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd0, 1'b1, 2'd1);
    checks++; if (bus.available !== 5'd3) begin errors++; $display("FAIL simul_avail got %0d exp 3", bus.available); end
    checks++; if (bus.rd_data_1 !== 3'd1 || bus.rd_data_2 !== 3'd2) begin errors++; $display("FAIL simul_pair1 got %0d,%0d exp 1,2", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd3 || bus.rd_data_2 !== 3'd4) begin errors++; $display("FAIL simul_pair2 got %0d,%0d exp 3,4", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd2 || bus.rd_data_2 !== 3'd4) begin errors++; $display("FAIL simul_pair3 got %0d,%0d exp 2,4", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.rd_data_1 !== 3'd1 || bus.rd_data_2 !== 3'd0) begin errors++; $display("FAIL simul_pair4 got %0d,%0d exp 1,0", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %0d exp 1", bus.empty); end
  endtask
  task automatic test_short_pop_and_reset;
    cyc(1'b1, 3'd2, 3'd5, 3'd5, 3'd0, 3'd0, 1'b1, 2'd2);
    checks++; if (bus.available !== 5'd8 || bus.rd_data_1 !== 3'd5) begin errors++; $display("FAIL no_bypass got avail=%0d rd1=%0d exp 8,5", bus.available, bus.rd_data_1); end
    pop(2'd2);
    wr(3'd1, 3'd3, 3'd0, 3'd0, 3'd0);
    checks++; if (bus.rd_data_1 !== 3'd3 || bus.rd_data_2 !== 3'd0) begin errors++; $display("FAIL short_pre got %0d,%0d exp 3,0", bus.rd_data_1, bus.rd_data_2); end
    pop(2'd2);
    checks++; if (bus.empty !== 1'b1 || bus.available !== 5'd10) begin errors++; $display("FAIL short_post got empty=%0d avail=%0d exp 1,10", bus.empty, bus.available); end
`ifdef TX_SEQ_REC_STATUS_EN
    checks++; if (bus.underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_err got %0d exp 1", bus.underflow_err); end
`endif
    pop(2'd1);
    wr(3'd2, 3'd1, 3'd2, 3'd0, 3'd0);
    checks++; if (bus.rd_data_1 !== 3'd1 || bus.rd_data_2 !== 3'd2) begin errors++; $display("FAIL no_overrun got %0d,%0d exp 1,2", bus.rd_data_1, bus.rd_data_2); end
    wr(3'd4, 3'd3, 3'd4, 3'd5, 3'd1);
    checks++; if (bus.available !== 5'd4) begin errors++; $display("FAIL burst_avail got %0d exp 4", bus.available); end
    bus.wr_en = 1'b1; bus.wr_mode = 3'd2;
    #2 arst = 1'b0;
    #1;
    checks++; if (bus.empty !== 1'b1 || bus.available !== 5'd10) begin errors++; $display("FAIL async_reset got empty=%0d avail=%0d exp 1,10", bus.empty, bus.available); end
    checks++; if (bus.rd_data_1 !== 3'd0 || bus.rd_data_2 !== 3'd0) begin errors++; $display("FAIL async_reset_rd got %0d,%0d exp 0,0", bus.rd_data_1, bus.rd_data_2); end
    bus.wr_en = 1'b0;
    @(negedge clk); arst = 1'b1;
    wr(3'd1, 3'd5, 3'd0, 3'd0, 3'd0);
    checks++; if (bus.rd_data_1 !== 3'd5 || bus.available !== 5'd9) begin errors++; $display("FAIL post_reset got rd1=%0d avail=%0d exp 5,9", bus.rd_data_1, bus.available); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    arst = 1'b0;
    bus.wr_en = 1'b0; bus.wr_mode = 3'd0; bus.rd_en = 1'b0; bus.rd_mode = 2'd0;
    bus.wr_data_1 = 3'd0; bus.wr_data_2 = 3'd0; bus.wr_data_3 = 3'd0; bus.wr_data_4 = 3'd0;
`ifdef TX_SEQ_REC_STATUS_EN
    bus.err_clr = 1'b0;
`endif
    test_reset();
    test_order();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_short_pop_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
